// File: rtl/mandelbrot_pixel_dispatcher_if.sv
// Mandelbrot dispatcher bus: the core operand/result handshake plus the
// outgoing pixel stream.
//   master : the dispatcher (drives core operands and the pixel stream)
//   slave  : core + pixel sink (returns escape count/done and pixel ready)
// Signal names keep the dispatcher-side direction suffix so they line up
// with the dispatcher's documented port list.
interface mandelbrot_pixel_dispatcher_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_ITER_WIDTH = 16
);
    // core side
    logic                      core_start_o;
    logic [DATA_WIDTH-1:0]     core_x0_o;
    logic [DATA_WIDTH-1:0]     core_y0_o;
    logic [MAX_ITER_WIDTH-1:0] core_max_iter_o;
    logic [MAX_ITER_WIDTH-1:0] core_iter_i;
    logic                      core_done_i;
    // pixel stream side
    logic                      pix_valid_o;
    logic                      pix_ready_i;
    logic [MAX_ITER_WIDTH-1:0] pix_iter_o;
    logic                      pix_sof_o;
    logic                      pix_eol_o;

    modport master (
        output core_start_o, core_x0_o, core_y0_o, core_max_iter_o,
        input  core_iter_i, core_done_i,
        output pix_valid_o, pix_iter_o, pix_sof_o, pix_eol_o,
        input  pix_ready_i
    );

    modport slave (
        input  core_start_o, core_x0_o, core_y0_o, core_max_iter_o,
        output core_iter_i, core_done_i,
        input  pix_valid_o, pix_iter_o, pix_sof_o, pix_eol_o,
        output pix_ready_i
    );
endinterface

// File: rtl/mandelbrot_pixel_dispatcher.sv
// Mandelbrot pixel dispatcher: scans a width x height frame in raster order,
// hands each pixel's c = x0 + i*y0 (signed Q8.24) to a single core, waits for
// its escape count and streams it out on a valid/ready pixel interface.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   frame_start_i          start a frame (only looked at while idle)
//   x_start_i, y_start_i   c of the top-left pixel
//   step_i                 pixel pitch (x grows right, y shrinks downward)
//   width_i, height_i      frame size in pixels
//   max_iter_i             iteration limit passed to the core
//   busy_o                 frame in progress
//   frame_done_o           one-cycle pulse after the last pixel is accepted
//   bus (master)           core operand/result handshake and pixel stream
module mandelbrot_pixel_dispatcher #(
    parameter int INTEGER_BITS    = 8,
    parameter int FRACTIONAL_BITS = 24,
    parameter int DATA_WIDTH      = INTEGER_BITS + FRACTIONAL_BITS,
    parameter int MAX_ITER_WIDTH  = 16,
    parameter int DIM_WIDTH       = 12
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      frame_start_i,
    input  logic [DATA_WIDTH-1:0]     x_start_i,
    input  logic [DATA_WIDTH-1:0]     y_start_i,
    input  logic [DATA_WIDTH-1:0]     step_i,
    input  logic [DIM_WIDTH-1:0]      width_i,
    input  logic [DIM_WIDTH-1:0]      height_i,
    input  logic [MAX_ITER_WIDTH-1:0] max_iter_i,
    output logic                      busy_o,
    output logic                      frame_done_o,
    mandelbrot_pixel_dispatcher_if.master bus
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, OUTPUT, DONE} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] x_start_q;
    logic [DATA_WIDTH-1:0] step_q;
    logic [DIM_WIDTH-1:0]  width_q;
    logic [DIM_WIDTH-1:0]  height_q;
    logic [DIM_WIDTH-1:0]  col_q;
    logic [DIM_WIDTH-1:0]  row_q;
    logic                  last_col;
    logic                  last_row;

    // width/height are never zero once a frame reaches ISSUE, so the -1 cannot wrap
    assign last_col = (col_q == width_q  - DIM_WIDTH'(1));
    assign last_row = (row_q == height_q - DIM_WIDTH'(1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state               <= IDLE;
            x_start_q           <= '0;
            step_q              <= '0;
            width_q             <= '0;
            height_q            <= '0;
            col_q               <= '0;
            row_q               <= '0;
            busy_o              <= 1'b0;
            frame_done_o        <= 1'b0;
            bus.core_start_o    <= 1'b0;
            bus.core_x0_o       <= '0;
            bus.core_y0_o       <= '0;
            bus.core_max_iter_o <= '0;
            bus.pix_valid_o     <= 1'b0;
            bus.pix_iter_o      <= '0;
            bus.pix_sof_o       <= 1'b0;
            bus.pix_eol_o       <= 1'b0;
        end else begin
            // both are single-cycle pulses
            bus.core_start_o <= 1'b0;
            frame_done_o     <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start_i) begin
                        x_start_q           <= x_start_i;
                        step_q              <= step_i;
                        width_q             <= width_i;
                        height_q            <= height_i;
                        col_q               <= '0;
                        row_q               <= '0;
                        bus.core_x0_o       <= x_start_i;
                        bus.core_y0_o       <= y_start_i;
                        bus.core_max_iter_o <= max_iter_i;
                        busy_o              <= 1'b1;
                        if (width_i == '0 || height_i == '0) begin
                            frame_done_o <= 1'b1;
                            state        <= DONE;
                        end else begin
                            bus.core_start_o <= 1'b1;
                            state            <= ISSUE;
                        end
                    end
                end
                // core_done_i is still the previous pixel's level here; skip it
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (bus.core_done_i) begin
                        bus.pix_iter_o  <= bus.core_iter_i;
                        bus.pix_valid_o <= 1'b1;
                        bus.pix_sof_o   <= (col_q == '0) && (row_q == '0);
                        bus.pix_eol_o   <= last_col;
                        state           <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (bus.pix_ready_i) begin
                        bus.pix_valid_o <= 1'b0;
                        bus.pix_sof_o   <= 1'b0;
                        bus.pix_eol_o   <= 1'b0;
                        if (last_col && last_row) begin
                            frame_done_o <= 1'b1;
                            state        <= DONE;
                        end else begin
                            // operands only move here, so they stay put while the core iterates
                            if (last_col) begin
                                col_q         <= '0;
                                row_q         <= row_q + DIM_WIDTH'(1);
                                bus.core_x0_o <= x_start_q;
                                bus.core_y0_o <= bus.core_y0_o - step_q;
                            end else begin
                                col_q         <= col_q + DIM_WIDTH'(1);
                                bus.core_x0_o <= bus.core_x0_o + step_q;
                            end
                            bus.core_start_o <= 1'b1;
                            state            <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mandelbrot_pixel_dispatcher.sv
module tb_mandelbrot_pixel_dispatcher;
    localparam int DW   = 32;
    localparam int MW   = 16;
    localparam int DIMW = 12;

    typedef struct packed {
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        logic [MW-1:0] mi;
        logic [MW-1:0] it;
        logic          sof;
        logic          eol;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            fs  = 1'b0;
    logic [DW-1:0]   xs  = '0;
    logic [DW-1:0]   ys  = '0;
    logic [DW-1:0]   st  = '0;
    logic [DIMW-1:0] w   = '0;
    logic [DIMW-1:0] h   = '0;
    logic [MW-1:0]   mi  = '0;
    logic            busy;
    logic            fdone;

    mandelbrot_pixel_dispatcher_if #(.DATA_WIDTH(DW), .MAX_ITER_WIDTH(MW)) bus ();

    mandelbrot_pixel_dispatcher #(
        .INTEGER_BITS(8), .FRACTIONAL_BITS(24), .DATA_WIDTH(DW),
        .MAX_ITER_WIDTH(MW), .DIM_WIDTH(DIMW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .frame_start_i(fs),
        .x_start_i(xs), .y_start_i(ys), .step_i(st),
        .width_i(w), .height_i(h), .max_iter_i(mi),
        .busy_o(busy), .frame_done_o(fdone), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard: cq checked at each core start, pq at each pixel handshake
    exp_t cq[$];
    exp_t pq[$];

    int n_starts   = 0;
    int n_fd       = 0;
    int n_hs       = 0;
    int cyc        = 0;
    int done_cyc   = -100;
    int lat        = 5;
    int stall_at   = -1;
    int stall_len  = 0;
    int stall_ctr  = 0;
    int stall_tot  = 0;
    int cnt        = 0;
    bit arm        = 1'b0;
    bit prev_valid = 1'b0;
    logic [MW-1:0] cur_iter = '0;
    logic [DW-1:0] cur_x    = '0;
    logic [DW-1:0] cur_y    = '0;
    exp_t ep;
    exp_t ec;

    // core responder, pixel sink and monitor, all on the falling edge
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            bus.core_done_i = 1'b0;
            bus.core_iter_i = '0;
            bus.pix_ready_i = 1'b0;
            cnt        = 0;
            arm        = 1'b0;
            stall_ctr  = 0;
            prev_valid = 1'b0;
        end else begin
            if (bus.pix_valid_o && n_hs == stall_at && stall_ctr < stall_len) begin
                bus.pix_ready_i = 1'b0;
                stall_ctr++;
                stall_tot++;
                if (pq.size() > 0) begin
                    chk("stall_iter", 64'(bus.pix_iter_o), 64'(pq[0].it));
                    chk("stall_x0",   64'(bus.core_x0_o),  64'(pq[0].x));
                    chk("stall_y0",   64'(bus.core_y0_o),  64'(pq[0].y));
                end
            end else begin
                bus.pix_ready_i = 1'b1;
            end
            if (bus.pix_valid_o) chk("start_in_output", 64'(bus.core_start_o), 64'd0);
            if (bus.pix_valid_o && !prev_valid) chk("valid_latency", 64'(cyc - done_cyc), 64'd1);
            if (bus.pix_valid_o && bus.pix_ready_i) begin
                if (pq.size() == 0) chk("unexpected_pixel", 64'd1, 64'd0);
                else begin
                    ep = pq.pop_front();
                    chk("pix_iter", 64'(bus.pix_iter_o), 64'(ep.it));
                    chk("pix_sof",  64'(bus.pix_sof_o),  64'(ep.sof));
                    chk("pix_eol",  64'(bus.pix_eol_o),  64'(ep.eol));
                end
                n_hs++;
                stall_ctr = 0;
            end
            prev_valid = bus.pix_valid_o;
            if (fdone) begin
                n_fd++;
                chk("done_after_last", 64'(pq.size()), 64'd0);
            end
            // core model: done stays high until the start is taken, then drops
            if (cnt > 0) begin
                chk("wait_x0", 64'(bus.core_x0_o), 64'(cur_x));
                chk("wait_y0", 64'(bus.core_y0_o), 64'(cur_y));
                cnt--;
                if (cnt == 0) begin
                    bus.core_done_i = 1'b1;
                    bus.core_iter_i = cur_iter;
                    done_cyc = cyc;
                end
            end
            if (arm) begin
                bus.core_done_i = 1'b0;
                cnt = lat;
                arm = 1'b0;
            end
            if (bus.core_start_o) begin
                n_starts++;
                if (cq.size() == 0) chk("unexpected_start", 64'd1, 64'd0);
                else begin
                    ec = cq.pop_front();
                    chk("core_x0",       64'(bus.core_x0_o),       64'(ec.x));
                    chk("core_y0",       64'(bus.core_y0_o),       64'(ec.y));
                    chk("core_max_iter", 64'(bus.core_max_iter_o), 64'(ec.mi));
                    cur_iter = ec.it;
                    cur_x    = ec.x;
                    cur_y    = ec.y;
                    arm      = 1'b1;
                end
            end
        end
    end

    task automatic step_cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic launch(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic [DW-1:0] s,
                          input int wi, input int he, input int m, input int base, input int l);
        exp_t e;
        xs = x; ys = y; st = s; w = DIMW'(wi); h = DIMW'(he); mi = MW'(m); lat = l;
        for (int r = 0; r < he && wi > 0; r++) begin
            for (int c = 0; c < wi; c++) begin
                e.x   = x + DW'(c) * s;
                e.y   = y - DW'(r) * s;
                e.mi  = MW'(m);
                e.it  = MW'(base + r * wi + c);
                e.sof = (r == 0 && c == 0);
                e.eol = (c == wi - 1);
                cq.push_back(e);
                pq.push_back(e);
            end
        end
        fs = 1'b1;
        step_cyc(1);
        fs = 1'b0;
    endtask

    task automatic wait_fd(input int target);
        int t = 0;
        while (n_fd < target && t < 3000) begin
            step_cyc(1);
            t++;
        end
        chk("frame_done_timeout", 64'(n_fd >= target), 64'd1);
    endtask

    task automatic wait_starts(input int target);
        int t = 0;
        while (n_starts < target && t < 3000) begin
            step_cyc(1);
            t++;
        end
        chk("start_timeout", 64'(n_starts >= target), 64'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, 64'({bus.core_start_o, bus.core_x0_o, bus.core_y0_o, bus.core_max_iter_o,
                      bus.pix_valid_o, bus.pix_iter_o, bus.pix_sof_o, bus.pix_eol_o, busy, fdone}), 64'd0);
    endtask

    int s0;
    int f0;

    initial begin
        // reset, then idle with no frame request
        step_cyc(3);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step_cyc(1);
            chk_all_zero("idle_outputs");
        end
        chk("idle_no_start", 64'(n_starts), 64'd0);

        // 2x2 frame at (-2,1) pitch 1, core latency 5
        s0 = n_starts; f0 = n_fd;
        launch(32'hFE000000, 32'h01000000, 32'h01000000, 2, 2, 10, 3, 5);
        wait_fd(f0 + 1);
        step_cyc(1);
        chk("f1_starts", 64'(n_starts - s0), 64'd4);
        chk("f1_done_pulses", 64'(n_fd - f0), 64'd1);
        chk("f1_idle_busy", 64'(busy), 64'd0);

        // same frame, pixel 1 back-pressured 7 cycles, plus a frame_start while busy
        s0 = n_starts; f0 = n_fd;
        stall_at = n_hs + 1; stall_len = 7; stall_tot = 0;
        launch(32'hFE000000, 32'h01000000, 32'h01000000, 2, 2, 10, 3, 5);
        wait_starts(s0 + 2);
        fs = 1'b1;
        step_cyc(1);
        fs = 1'b0;
        wait_fd(f0 + 1);
        step_cyc(3);
        chk("f2_stall_cycles", 64'(stall_tot), 64'd7);
        chk("f2_starts", 64'(n_starts - s0), 64'd4);
        chk("f2_done_pulses", 64'(n_fd - f0), 64'd1);
        stall_at = -1;

        // 3x2 frame wrapping both coordinates, stale done and latency 3
        s0 = n_starts; f0 = n_fd;
        launch(32'h7F800000, 32'h80400000, 32'h00800000, 3, 2, 100, 20, 3);
        wait_fd(f0 + 1);
        step_cyc(1);
        chk("f3_starts", 64'(n_starts - s0), 64'd6);

        // zero width: done the cycle after the request, no core start
        s0 = n_starts; f0 = n_fd;
        xs = 32'h0; ys = 32'h0; st = 32'h01000000; w = '0; h = DIMW'(5); mi = MW'(7);
        fs = 1'b1;
        step_cyc(1);
        fs = 1'b0;
        chk("zero_done_t1", 64'(fdone), 64'd1);
        chk("zero_busy_t1", 64'(busy), 64'd1);
        step_cyc(1);
        chk("zero_done_pulse", 64'(fdone), 64'd0);
        step_cyc(2);
        chk("zero_no_start", 64'(n_starts - s0), 64'd0);
        chk("zero_done_count", 64'(n_fd - f0), 64'd1);

        // reset while waiting on pixel 2, then a clean restart
        s0 = n_starts; f0 = n_fd;
        launch(32'hFF000000, 32'h00800000, 32'h00400000, 3, 2, 50, 40, 5);
        wait_starts(s0 + 3);
        step_cyc(2);
        rst = 1'b1;
        step_cyc(1);
        chk_all_zero("reset_mid_frame");
        rst = 1'b0;
        cq.delete();
        pq.delete();
        step_cyc(2);
        chk("reset_no_done", 64'(n_fd - f0), 64'd0);
        s0 = n_starts; f0 = n_fd;
        launch(32'hFE000000, 32'h01000000, 32'h01000000, 2, 2, 10, 60, 4);
        wait_fd(f0 + 1);
        step_cyc(1);
        chk("restart_starts", 64'(n_starts - s0), 64'd4);
        chk("restart_drained", 64'(pq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/mandelbrot_pixel_dispatcher.md
Name: mandelbrot_pixel_dispatcher

Overview:
- Initiator side of the Mandelbrot core interface. Scans a WIDTH x HEIGHT pixel frame in raster order and computes each pixel's complex coordinate c = x0 + i*y0 in Q8.24.
- Per pixel: issues one start to a single core, holds the operands while the core iterates, collects the escape count, and emits it on a valid/ready pixel stream toward the frame buffer/VGA path.

Parameters:
- INTEGER_BITS, 8, integer bits of coordinate format
- FRACTIONAL_BITS, 24, fractional bits of coordinate format
- DATA_WIDTH, INTEGER_BITS+FRACTIONAL_BITS, coordinate word width
- MAX_ITER_WIDTH, 16, iteration count width
- DIM_WIDTH, 12, width of frame dimension and pixel counters

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous active-high reset
- frame_start_i  in  1  request a new frame; sampled only in IDLE
- x_start_i  in  DATA_WIDTH  signed Q8.24 real part of column 0
- y_start_i  in  DATA_WIDTH  signed Q8.24 imaginary part of row 0 (top row)
- step_i  in  DATA_WIDTH  signed Q8.24 pixel pitch
- width_i  in  DIM_WIDTH  pixels per row
- height_i  in  DIM_WIDTH  rows per frame
- max_iter_i  in  MAX_ITER_WIDTH  iteration limit for the frame
- core_start_o  out  1  one-cycle start pulse to the core
- core_x0_o  out  DATA_WIDTH  real part of c to the core
- core_y0_o  out  DATA_WIDTH  imaginary part of c to the core
- core_max_iter_o  out  MAX_ITER_WIDTH  iteration limit to the core
- core_iter_i  in  MAX_ITER_WIDTH  escape count from the core
- core_done_i  in  1  core completion; level, stays high until the next start
- pix_valid_o  out  1  pixel result valid
- pix_ready_i  in  1  downstream accepts pixel
- pix_iter_o  out  MAX_ITER_WIDTH  escape count of the current pixel
- pix_sof_o  out  1  current pixel is (0,0)
- pix_eol_o  out  1  current pixel is the last in its row
- busy_o  out  1  frame in progress (state != IDLE)
- frame_done_o  out  1  one-cycle pulse after the last pixel handshake

Behaviour:
Reset:
- All outputs 0, state IDLE, counters 0, coordinates 0.
- Reset mid-frame aborts immediately with no pixel or frame_done emitted. The core shares rst_i.

Frame start:
- In IDLE, frame_start_i=1 at edge t latches x_start, y_start, step, width, height, max_iter.
- Sets col=row=0, core_x0=x_start, core_y0=y_start.
- frame_start_i is ignored when not in IDLE.
- width_i==0 or height_i==0: go directly to DONE; frame_done_o pulses at cycle t+1 and no core_start is issued.

States:
- IDLE -> ISSUE
  - core_start_o=1 for exactly this one cycle -> WAIT.
- WAIT:
  - core_done_i is ignored in the ISSUE cycle, because a stale done from the previous pixel is still high then.
  - In WAIT, core_done_i=1 captures core_iter_i into pix_iter_o -> OUTPUT.
- OUTPUT:
  - pix_valid_o=1, with pix_iter_o/sof/eol stable until pix_valid_o && pix_ready_i (AXI-style, no combinational ready->valid path).
  - On handshake:
    - last pixel -> DONE
    - col==width-1 -> col=0, row+1, core_x0=x_start, core_y0-=step; -> ISSUE
    - else col+1, core_x0+=step; -> ISSUE
- DONE:
  - frame_done_o=1 for one cycle -> IDLE.

Operand rules:
- core_x0_o, core_y0_o and core_max_iter_o stay constant from ISSUE until the OUTPUT handshake. The core re-reads c every iteration.
- Coordinate arithmetic is two's-complement DATA_WIDTH add/subtract with wrap, no saturation. Rows descend in imaginary part.

Latency:
- pix_valid_o rises the cycle after core_done_i is first sampled high in WAIT.
- Minimum overhead is 3 cycles per pixel beyond core time: ISSUE, done capture, and the handshake cycle.

Flags:
- pix_sof_o=1 when col==0 and row==0.
- pix_eol_o=1 when col==width-1.
- Both are valid only with pix_valid_o.

Test Plan:
- Reset, then hold frame_start_i=0 for 10 cycles -> all outputs 0, busy_o=0, no core_start_o.
- 2x2 frame: x_start=0xFE000000 (-2.0), y_start=0x01000000 (1.0), step=0x01000000, max_iter=10; responder model returns iter=3,4,5,6 after 5 cycles each -> core (x0,y0) = (-2,1),(-1,1),(-2,0),(-1,0); pixels 3,4,5,6 with sof on pixel 0, eol on pixels 1 and 3; one frame_done_o pulse; exactly 4 core_start_o pulses.
- Same frame with pix_ready_i held low 7 cycles on pixel 1 -> pix_iter_o=4 stable, no new core_start_o until handshake, operands unchanged.
- Responder leaves done high from the previous pixel and delays new completion 3 cycles -> stale done is not captured; pix_valid_o rises 1 cycle after the new done.
- width_i=0, height_i=5 -> frame_done_o pulses at t+1, no core_start_o; frame_start_i asserted mid-frame has no effect.
- rst_i asserted during WAIT of pixel 2 -> next cycle all outputs 0, IDLE; a subsequent frame_start_i restarts at pixel (0,0) with sof.
